// File: rtl/slowsym_tapload.sv
// Coefficient loader for a slow symmetric FIR: collects half the taps into a shadow
// memory, then resets the filter and streams the taps in, gating samples meanwhile.
module slowsym_tapload #(
    parameter int               LGNTAPS = 7,
    parameter int               TW      = 12,
    parameter int               IW      = 16,
    parameter logic [LGNTAPS:0] NTAPS   = 107
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic          i_valid,
    input  logic [TW-1:0] i_coeff,
    output logic          o_ready,
    input  logic          i_ce,
    input  logic [IW-1:0] i_sample,
    output logic          o_fil_reset,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_ce,
    output logic [IW-1:0] o_sample,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_overrun,
    output logic [15:0]   o_dropped
);
    localparam int NLOAD = (int'(NTAPS) + 1) / 2;
    localparam int AW    = LGNTAPS - 1;
    localparam logic [LGNTAPS-1:0] LAST = LGNTAPS'(NLOAD - 1);
    localparam logic [LGNTAPS-1:0] NL   = LGNTAPS'(NLOAD);

    typedef enum logic [1:0] {IDLE, COLLECT, FILRST, WRITE} state_t;

    state_t               state;
    logic [LGNTAPS-1:0]   wptr, rptr;
    logic [TW-1:0]        mem [0:(1<<AW)-1];
    logic [LGNTAPS:0]     spacing;
    logic                 coeff_wr, gated, fwd, drop;

    // Start beats a same-cycle handshake, so the coefficient is not stored.
    assign coeff_wr = (state == COLLECT) && !i_start && i_valid;
    assign gated    = (state == FILRST) || (state == WRITE);
    assign fwd      = i_ce && !gated && (spacing == '0);
    assign drop     = i_ce && !fwd;

    // Shadow memory is deliberately not reset so an abandoned load leaves it intact.
    always_ff @(posedge i_clk) begin
        if (coeff_wr)
            mem[wptr[AW-1:0]] <= i_coeff;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            o_ready     <= 1'b0;
            o_tap_wr    <= 1'b0;
            o_tap       <= '0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
            o_fil_reset <= 1'b1;
        end else begin
            o_done      <= 1'b0;
            o_fil_reset <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    state   <= COLLECT;
                    wptr    <= '0;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b1;
                end
                COLLECT: begin
                    if (i_start)
                        wptr <= '0;
                    else if (i_valid) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == LAST) begin
                            state       <= FILRST;
                            o_ready     <= 1'b0;
                            o_fil_reset <= 1'b1;
                        end
                    end
                end
                FILRST: begin
                    state    <= WRITE;
                    o_tap_wr <= 1'b1;
                    o_tap    <= mem[0];
                    rptr     <= LGNTAPS'(1);
                end
                WRITE: begin
                    if (rptr == NL) begin
                        state    <= IDLE;
                        o_tap_wr <= 1'b0;
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                        rptr     <= '0;
                    end else begin
                        o_tap <= mem[rptr[AW-1:0]];
                        rptr  <= rptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Spacing counter holds off samples until the filter has had NTAPS+1 cycles.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_ce      <= 1'b0;
            o_sample  <= '0;
            spacing   <= '0;
            o_overrun <= 1'b0;
            o_dropped <= '0;
        end else begin
            o_ce     <= fwd;
            o_sample <= i_sample;
            if (fwd)
                spacing <= NTAPS;
            else if (spacing != '0)
                spacing <= spacing - 1'b1;
            if (i_ce && (spacing != '0))
                o_overrun <= 1'b1;
            if (drop && (o_dropped != 16'hFFFF))
                o_dropped <= o_dropped + 1'b1;
        end
    end
endmodule

// File: tb/tb_slowsym_tapload.sv
// Directed bench for slowsym_tapload: tap values checked against a queue of
// coefficients pushed as they are sent; sample gating checked against a fixed timeline.
module tb_slowsym_tapload;
    localparam int             LGNTAPS = 3;
    localparam int             TW      = 12;
    localparam int             IW      = 16;
    localparam logic [3:0]     NTAPS   = 4'd7;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_valid = 1'b0;
    logic [TW-1:0] i_coeff = '0;
    logic          o_ready;
    logic          i_ce = 1'b0;
    logic [IW-1:0] i_sample = '0;
    logic          o_fil_reset, o_tap_wr, o_ce, o_busy, o_done, o_overrun;
    logic [TW-1:0] o_tap;
    logic [IW-1:0] o_sample;
    logic [15:0]   o_dropped;

    slowsym_tapload #(.LGNTAPS(LGNTAPS), .TW(TW), .IW(IW), .NTAPS(NTAPS)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_valid(i_valid),
        .i_coeff(i_coeff), .o_ready(o_ready), .i_ce(i_ce), .i_sample(i_sample),
        .o_fil_reset(o_fil_reset), .o_tap_wr(o_tap_wr), .o_tap(o_tap), .o_ce(o_ce),
        .o_sample(o_sample), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun),
        .o_dropped(o_dropped)
    );

    always #5 i_clk = ~i_clk;

    int            checks = 0;
    int            failures = 0;
    int            tap_cnt = 0;
    logic [TW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [TW-1:0] v, input bit push);
        i_valid = 1'b1;
        i_coeff = v;
        if (push) exp_q.push_back(v);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (o_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_done_idle"}, 32'(o_busy), 32'd0);
        tick();
        check({tag, "_done_once"}, 32'(o_done), 32'd0);
    endtask

    // Scoreboard: every tap write must match the oldest coefficient still expected.
    always @(negedge i_clk) begin
        if (o_tap_wr === 1'b1) begin
            tap_cnt++;
            check("tap_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tap_value", 32'(o_tap), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int base;
        bit exp_ce;

        tick(); tick();
        check("rst_fil_reset", 32'(o_fil_reset), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_tap_wr", 32'(o_tap_wr), 32'd0);
        check("rst_dropped", 32'(o_dropped), 32'd0);
        check("rst_tap", 32'(o_tap), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        i_reset_n = 1'b1;
        tick();
        check("rel_fil_reset", 32'(o_fil_reset), 32'd0);

        // Basic load 1,2,3,4
        base = tap_cnt;
        i_start = 1'b1; tick(); i_start = 1'b0;
        check("load1_busy", 32'(o_busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("load1_ready", 32'(o_ready), 32'd1);
            send(TW'(k), 1'b1);
        end
        check("load1_filrst", 32'(o_fil_reset), 32'd1);
        check("load1_ready_off", 32'(o_ready), 32'd0);
        check("load1_no_wr_in_filrst", 32'(o_tap_wr), 32'd0);
        wait_done("load1");
        check("load1_q_empty", 32'(exp_q.size()), 32'd0);
        check("load1_wr_count", 32'(tap_cnt - base), 32'd4);

        // Restart mid-collect; the coefficient on the start cycle is discarded
        base = tap_cnt;
        i_start = 1'b1; tick(); i_start = 1'b0;
        send(12'd5, 1'b0);
        send(12'd6, 1'b0);
        i_start = 1'b1; send(12'd9, 1'b0); i_start = 1'b0;
        send(12'd7, 1'b1); send(12'd8, 1'b1); send(12'd9, 1'b1); send(12'd10, 1'b1);
        check("restart_filrst", 32'(o_fil_reset), 32'd1);
        wait_done("restart");
        check("restart_q_empty", 32'(exp_q.size()), 32'd0);
        check("restart_wr_count", 32'(tap_cnt - base), 32'd4);

        // Two loads with i_ce every 8 cycles; starts during FILRST/WRITE are ignored
        for (int c = 0; c < 40; c++) begin
            i_start  = (c == 0) || (c == 20) || (c == 5) || (c == 7);
            i_valid  = ((c >= 1) && (c <= 4)) || ((c >= 21) && (c <= 24));
            i_coeff  = (c < 20) ? TW'(10 + c) : TW'(10 + c);
            if (i_valid) exp_q.push_back(i_coeff);
            i_ce     = (c % 8) == 5;
            i_sample = IW'(c * 3 + 1);
            exp_ce   = i_ce && !(((c >= 5) && (c <= 9)) || ((c >= 25) && (c <= 29)));
            tick();
            check("gate_ce", 32'(o_ce), 32'(exp_ce));
            if (exp_ce) check("gate_sample", 32'(o_sample), 32'(c * 3 + 1));
        end
        i_start = 1'b0; i_valid = 1'b0; i_ce = 1'b0;
        check("gate_q_empty", 32'(exp_q.size()), 32'd0);
        check("gate_dropped", 32'(o_dropped), 32'd2);
        check("gate_overrun", 32'(o_overrun), 32'd0);

        // Spacing: ce at 0 forwarded, at 5 dropped, at 8 forwarded again
        i_reset_n = 1'b0; tick(); i_reset_n = 1'b1; tick();
        i_ce = 1'b1; i_sample = 16'hAAAA; tick(); i_ce = 1'b0;
        check("space_first_ce", 32'(o_ce), 32'd1);
        check("space_first_sample", 32'(o_sample), 32'hAAAA);
        repeat (4) tick();
        check("space_idle_ce", 32'(o_ce), 32'd0);
        i_ce = 1'b1; tick(); i_ce = 1'b0;
        check("space_drop_ce", 32'(o_ce), 32'd0);
        check("space_overrun", 32'(o_overrun), 32'd1);
        check("space_dropped", 32'(o_dropped), 32'd1);
        tick(); tick();
        i_ce = 1'b1; tick(); i_ce = 1'b0;
        check("space_edge_ce", 32'(o_ce), 32'd1);
        check("space_edge_dropped", 32'(o_dropped), 32'd1);
        tick();
        check("space_overrun_sticky", 32'(o_overrun), 32'd1);

        // Reset after two tap writes abandons the load
        i_reset_n = 1'b0; tick(); i_reset_n = 1'b1; tick();
        base = tap_cnt;
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int k = 1; k <= 4; k++) send(TW'(k + 40), 1'b1);
        tick(); tick();
        i_reset_n = 1'b0; tick();
        check("wrrst_wr_count", 32'(tap_cnt - base), 32'd2);
        check("wrrst_tap_wr", 32'(o_tap_wr), 32'd0);
        check("wrrst_fil_reset", 32'(o_fil_reset), 32'd1);
        check("wrrst_busy", 32'(o_busy), 32'd0);
        check("wrrst_done", 32'(o_done), 32'd0);
        i_reset_n = 1'b1; tick();
        exp_q.delete();
        check("wrrst_rel_done", 32'(o_done), 32'd0);
        check("wrrst_rel_fil_reset", 32'(o_fil_reset), 32'd0);
        repeat (3) tick();
        check("wrrst_stay_idle", 32'(o_busy), 32'd0);

        // Saturation: continuous i_ce drops 7 of every 8 samples
        i_ce = 1'b1;
        repeat (75000) tick();
        check("sat_dropped", 32'(o_dropped), 32'hFFFF);
        check("sat_overrun", 32'(o_overrun), 32'd1);
        repeat (10) tick();
        check("sat_hold", 32'(o_dropped), 32'hFFFF);
        i_ce = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/slowsym_tapload.md
SLOWSYM_TAPLOAD -- requirements
Module: slowsym_tapload

Interface
REQ-001 SHALL have parameter LGNTAPS, default 7: log2 upper bound on filter length.
REQ-002 SHALL have parameter TW, default 12: coefficient width.
REQ-003 SHALL have parameter IW, default 16: sample width.
REQ-004 SHALL have parameter NTAPS, width LGNTAPS+1, default 107: filter length; odd; NLOAD=(NTAPS+1)/2 coefficients per load; NLOAD <= 2^(LGNTAPS-1).
REQ-005 SHALL have port i_clk, input, 1: the only clock; one clock, all logic on rising edge.
REQ-006 SHALL have port i_reset_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port i_start, input, 1: begin a new coefficient load.
REQ-008 SHALL have port i_valid, input, 1: host coefficient valid.
REQ-009 SHALL have port i_coeff, input, TW: host coefficient, outermost tap first, centre tap last.
REQ-010 SHALL have port o_ready, output, 1: coefficient accepted when i_valid && o_ready.
REQ-011 SHALL have port i_ce, input, 1: upstream sample strobe.
REQ-012 SHALL have port i_sample, input, IW: upstream sample.
REQ-013 SHALL have ports o_fil_reset (1), o_tap_wr (1) and o_tap (TW), all outputs: filter reset (active-high), tap write strobe, tap value.
REQ-014 SHALL have ports o_ce (1) and o_sample (IW), outputs: gated sample strobe and sample to the filter.
REQ-015 SHALL have ports o_busy (1), o_done (1), o_overrun (1) and o_dropped (16), all outputs: load in progress; one-cycle load-complete pulse; sticky spacing violation; saturating count of dropped samples.

Function
REQ-016 SHALL implement states IDLE, COLLECT, FILRST, WRITE; o_busy=1 in every state except IDLE.
REQ-017 SHALL go IDLE->COLLECT on i_start, with write pointer cleared to 0.
REQ-018 In COLLECT, o_ready SHALL be 1, and each accepted coefficient SHALL be stored in shadow memory[wptr] with wptr incremented.
REQ-019 SHALL go COLLECT->FILRST on the cycle the NLOAD-th coefficient is accepted; o_ready SHALL be 0 outside COLLECT.
REQ-020 i_start in COLLECT SHALL restart the load (wptr=0); when i_start and a handshake occur in the same cycle, start wins and the coefficient is discarded.
REQ-021 i_start in FILRST or WRITE SHALL be ignored.
REQ-022 In FILRST (exactly one cycle), o_fil_reset SHALL be 1 and o_tap_wr SHALL be 0; the next state is WRITE.
REQ-023 In WRITE, o_tap_wr SHALL be 1 for exactly NLOAD consecutive cycles, with o_tap = shadow[0..NLOAD-1] in order, both registered.
REQ-024 After the last write, the block SHALL go to IDLE and o_done SHALL be 1 for exactly one cycle, the first IDLE cycle.
REQ-025 The filter's previously loaded taps SHALL stay in use during COLLECT, because the shadow memory is separate.
REQ-026 o_ce and o_sample SHALL be registered from i_ce and i_sample, 1-cycle latency.
REQ-027 o_ce SHALL be forced to 0 while the state is FILRST or WRITE; every suppressed i_ce SHALL increment o_dropped.
REQ-028 A spacing counter SHALL be loaded when a sample is forwarded; an i_ce fewer than NTAPS+1 cycles after the previous forwarded sample SHALL be dropped, counted in o_dropped, and SHALL set o_overrun.
REQ-029 o_overrun SHALL be cleared only by reset.
REQ-030 o_dropped SHALL saturate at 16'hFFFF, and SHALL not wrap.
REQ-031 The first i_ce after reset SHALL always be forwarded, subject to REQ-027.

Reset
REQ-032 When i_reset_n=0 at a clock edge, the state SHALL become IDLE and wptr and rptr SHALL be cleared.
REQ-033 On that edge, o_ready, o_tap_wr, o_ce, o_done, o_busy and o_overrun SHALL become 0, o_dropped 0, o_tap 0 and o_sample 0.
REQ-034 On that edge, o_fil_reset SHALL become 1.
REQ-035 o_fil_reset SHALL return to 0 on the first edge with i_reset_n=1, unless the block is in FILRST.
REQ-036 Reset mid-COLLECT or mid-WRITE SHALL abandon the load; the shadow memory contents are not cleared.

Verification (LGNTAPS=3, NTAPS=7, NLOAD=4, TW=12)
REQ-037 Start, then send 1,2,3,4 back-to-back -> o_ready high 4 cycles; one FILRST cycle; o_tap_wr 4 cycles carrying 1,2,3,4; o_done pulse once.
REQ-038 Start, send 5,6, then raise i_start together with coefficient 9, then send 7,8,9,10 -> taps written are 7,8,9,10; 9 from the start cycle is absent.
REQ-039 i_ce pulsed every 8 cycles during a load -> pulses landing in FILRST or WRITE are absent on o_ce; o_dropped equals the count of them; o_overrun stays 0.
REQ-040 i_ce at cycles 0 and 5 (idle) -> first forwarded at cycle 1; second dropped; o_overrun=1; o_dropped=1.
REQ-041 Reset asserted during WRITE after 2 taps -> next cycle: o_tap_wr=0, o_fil_reset=1, o_busy=0, no o_done.
REQ-042 o_dropped preset to near saturation via 65540 suppressed samples -> o_dropped holds 16'hFFFF.
